// File: rtl/approx_mul_err_sweep_if.sv
// Bus between the error-sweep engine and its environment: operand drive,
// product return, sweep control and the accumulated error statistics.
interface approx_mul_err_sweep_if #(
  parameter int ACC_W = 32
);
  logic             start;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [15:0]      prod_in;
  logic             busy;
  logic             done;
  logic [16:0]      err_cnt;
  logic [ACC_W-1:0] err_abs_sum;
  logic [ACC_W:0]   err_sgn_sum;
  logic [15:0]      err_max;
  logic [7:0]       err_max_a;
  logic [7:0]       err_max_b;

  // Environment side: issues start and returns the multiplier product.
  modport master (
    output start, prod_in,
    input  op_a, op_b, busy, done, err_cnt, err_abs_sum, err_sgn_sum,
           err_max, err_max_a, err_max_b
  );

  // Engine side.
  modport slave (
    input  start, prod_in,
    output op_a, op_b, busy, done, err_cnt, err_abs_sum, err_sgn_sum,
           err_max, err_max_a, err_max_b
  );
endinterface

// File: rtl/approx_mul_err_sweep.sv
// Exhaustive 8x8 approximate-multiplier error sweep. Walks every (a,b) pair,
// compares the returned product against the exact product and accumulates
// error count, absolute/signed error sums and the first worst-case pair.
module approx_mul_err_sweep #(
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  approx_mul_err_sweep_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Magnitude of a 17-bit two's complement difference; always fits 16 bits.
  function automatic logic [15:0] abs17(input logic [16:0] d);
    logic [16:0] n;
    n = 17'd0 - d;
    if (d[16]) begin
      return n[15:0];
    end else begin
      return d[15:0];
    end
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             busy_s;
  logic             done_s;
  logic             load_s;
  logic             run_s;
  logic             busy_r;
  logic             done_r;

  logic [7:0]       op_a_r;
  logic [7:0]       op_b_r;
  logic [15:0]      exact_s;

  logic             s1_valid_r;
  logic [7:0]       s1_a_r;
  logic [7:0]       s1_b_r;
  logic [15:0]      s1_exact_r;
  logic [15:0]      s1_prod_r;

  logic [16:0]      diff_s;
  logic [15:0]      abs_s;

  logic [16:0]      err_cnt_r;
  logic [ACC_W-1:0] err_abs_sum_r;
  logic [ACC_W:0]   err_sgn_sum_r;
  logic [15:0]      err_max_r;
  logic [7:0]       err_max_a_r;
  logic [7:0]       err_max_b_r;

  // Reference product uses plain unsigned arithmetic, independent of the DUT path.
  assign exact_s = {8'd0, op_a_r} * {8'd0, op_b_r};
  assign diff_s  = {1'b0, s1_prod_r} - {1'b0, s1_exact_r};
  assign abs_s   = abs17(diff_s);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: RUN ends once the last pair (255,255) is on the bus.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ({op_a_r, op_b_r} == 16'hFFFF) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: control strobes from the current state, status from the next.
  always_comb begin
    load_s = 1'b0;
    run_s  = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = bus.start;
      ST_RUN:  run_s  = 1'b1;
      default: run_s  = 1'b0;
    endcase
    case (state_s)
      ST_RUN:   busy_s = 1'b1;
      ST_DRAIN: busy_s = 1'b1;
      ST_DONE:  done_s = 1'b1;
      default:  busy_s = 1'b0;
    endcase
  end

  // Registered busy/done so status outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Operand counter, b in the low byte; parks on (255,255) after the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r <= 8'd0;
      op_b_r <= 8'd0;
    end else if (load_s) begin
      op_a_r <= 8'd0;
      op_b_r <= 8'd0;
    end else if (run_s && ({op_a_r, op_b_r} != 16'hFFFF)) begin
      {op_a_r, op_b_r} <= {op_a_r, op_b_r} + 16'd1;
    end
  end

  // S1: capture the pair, its exact product and the returned product.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 8'd0;
      s1_b_r     <= 8'd0;
      s1_exact_r <= 16'd0;
      s1_prod_r  <= 16'd0;
    end else begin
      s1_valid_r <= run_s;
      s1_a_r     <= op_a_r;
      s1_b_r     <= op_b_r;
      s1_exact_r <= exact_s;
      s1_prod_r  <= bus.prod_in;
    end
  end

  // S2: accumulate statistics; ties on the maximum keep the earlier pair.
  always_ff @(posedge clk) begin
    if (rst || load_s) begin
      err_cnt_r     <= 17'd0;
      err_abs_sum_r <= {ACC_W{1'b0}};
      err_sgn_sum_r <= {(ACC_W+1){1'b0}};
      err_max_r     <= 16'd0;
      err_max_a_r   <= 8'd0;
      err_max_b_r   <= 8'd0;
    end else if (s1_valid_r) begin
      if (diff_s != 17'd0) begin
        err_cnt_r <= err_cnt_r + 17'd1;
      end
      err_abs_sum_r <= err_abs_sum_r + {{(ACC_W-16){1'b0}}, abs_s};
      err_sgn_sum_r <= err_sgn_sum_r + {{(ACC_W-16){diff_s[16]}}, diff_s};
      if (abs_s > err_max_r) begin
        err_max_r   <= abs_s;
        err_max_a_r <= s1_a_r;
        err_max_b_r <= s1_b_r;
      end
    end
  end

  assign bus.op_a        = op_a_r;
  assign bus.op_b        = op_b_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.err_cnt     = err_cnt_r;
  assign bus.err_abs_sum = err_abs_sum_r;
  assign bus.err_sgn_sum = err_sgn_sum_r;
  assign bus.err_max     = err_max_r;
  assign bus.err_max_a   = err_max_a_r;
  assign bus.err_max_b   = err_max_b_r;

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Bench for approx_mul_err_sweep: six engines run in parallel, each fed by
// its own multiplier stub, so one sweep length covers all scenarios.
module tb_approx_mul_err_sweep;

  localparam int NI = 6;

  typedef struct packed {
    logic [16:0] cnt;
    logic [31:0] abs_sum;
    logic [32:0] sgn_sum;
    logic [15:0] mx;
    logic [7:0]  ma;
    logic [7:0]  mb;
  } stats_t;

  typedef struct {
    int     mode;
    stats_t st;
  } vec_t;

  typedef struct {
    int     inst;
    int     cyc;
    stats_t st;
  } sb_t;

  logic        clk;
  int          ecount = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n0 = 0;
  int          mon_idx;
  sb_t         sb_q[$];
  vec_t        tbl[4];
  stats_t      gen_full;
  stats_t      gen_part;

  logic        start_v [NI];
  logic        rst_v   [NI];
  logic [7:0]  opa_o   [NI];
  logic [7:0]  opb_o   [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
  logic [16:0] cnt_o   [NI];
  logic [31:0] abs_o   [NI];
  logic [32:0] sgn_o   [NI];
  logic [15:0] max_o   [NI];
  logic [7:0]  ma_o    [NI];
  logic [7:0]  mb_o    [NI];

  // Multiplier stubs: 0 exact, 1 lsb cleared, 2 zero, 3 one-off at (17,3), 4 mixed.
  function automatic logic [15:0] prod_f(input int mode, input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'(b);
    case (mode)
      0: return 16'(p);
      1: return 16'(p) & 16'hFFFE;
      2: return 16'h0000;
      3: return (a == 8'd17 && b == 8'd3) ? 16'(p + 1) : 16'(p);
      default: return 16'(p + int'((a ^ b) & 8'h07) - int'(a & b & 8'h03));
    endcase
  endfunction

  // Reference statistics over the first npairs pairs in sweep order.
  function automatic stats_t model(input int mode, input int npairs);
    stats_t s;
    longint asum;
    longint ssum;
    int d;
    int ad;
    logic [7:0] a;
    logic [7:0] b;
    s = '0;
    asum = 0;
    ssum = 0;
    for (int idx = 0; idx < npairs; idx++) begin
      a = 8'(idx >> 8);
      b = 8'(idx & 255);
      d = int'(prod_f(mode, a, b)) - int'(a) * int'(b);
      ad = (d < 0) ? -d : d;
      if (d != 0) s.cnt = s.cnt + 17'd1;
      asum += ad;
      ssum += d;
      if (ad > int'(s.mx)) begin
        s.mx = 16'(ad);
        s.ma = a;
        s.mb = b;
      end
    end
    s.abs_sum = 32'(asum);
    s.sgn_sum = 33'(ssum);
    return s;
  endfunction

  function automatic stats_t mk(input logic [16:0] c, input logic [31:0] as, input logic [32:0] ss,
                                input logic [15:0] mx, input logic [7:0] ma, input logic [7:0] mb);
    stats_t s;
    s.cnt = c; s.abs_sum = as; s.sgn_sum = ss; s.mx = mx; s.ma = ma; s.mb = mb;
    return s;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, ecount - n0, act, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int i, input stats_t e);
    chk({tag, "_err_cnt"}, i, 64'(cnt_o[i]), 64'(e.cnt));
    chk({tag, "_err_abs_sum"}, i, 64'(abs_o[i]), 64'(e.abs_sum));
    chk({tag, "_err_sgn_sum"}, i, 64'(sgn_o[i]), 64'(e.sgn_sum));
    chk({tag, "_err_max"}, i, 64'(max_o[i]), 64'(e.mx));
    chk({tag, "_err_max_a"}, i, 64'(ma_o[i]), 64'(e.ma));
    chk({tag, "_err_max_b"}, i, 64'(mb_o[i]), 64'(e.mb));
  endtask

  task automatic check_reset(input int i);
    chk("rst_op_a", i, 64'(opa_o[i]), 64'd0);
    chk("rst_op_b", i, 64'(opb_o[i]), 64'd0);
    chk("rst_busy", i, 64'(busy_o[i]), 64'd0);
    chk("rst_done", i, 64'(done_o[i]), 64'd0);
    check_stats("rst", i, '0);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    approx_mul_err_sweep_if #(.ACC_W(32)) bus ();
    assign bus.start   = start_v[g];
    assign bus.prod_in = prod_f((g < 4) ? g : 4, bus.op_a, bus.op_b);
    assign opa_o[g]  = bus.op_a;
    assign opb_o[g]  = bus.op_b;
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign cnt_o[g]  = bus.err_cnt;
    assign abs_o[g]  = bus.err_abs_sum;
    assign sgn_o[g]  = bus.err_sgn_sum;
    assign max_o[g]  = bus.err_max;
    assign ma_o[g]   = bus.err_max_a;
    assign mb_o[g]   = bus.err_max_b;
    approx_mul_err_sweep #(.ACC_W(32)) dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus)
    );
  end

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time every observation.
  always @(posedge clk) ecount <= ecount + 1;

  // Scoreboard: each done pulse must match a pending expectation exactly.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (done_o[i] === 1'b1) begin
        mon_idx = -1;
        foreach (sb_q[j]) if (mon_idx < 0 && sb_q[j].inst == i) mon_idx = j;
        if (mon_idx < 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done inst%0d cycle %0d: got done=1 expected no pulse", i, ecount - n0);
        end else begin
          chk("done_cycle", i, 64'(ecount - n0), 64'(sb_q[mon_idx].cyc - n0));
          check_stats("at_done", i, sb_q[mon_idx].st);
          sb_q.delete(mon_idx);
        end
      end
    end
  end

  initial begin
    tbl[0] = '{mode: 0, st: mk(17'd0, 32'd0, 33'd0, 16'd0, 8'd0, 8'd0)};
    tbl[1] = '{mode: 1, st: mk(17'd16384, 32'd16384, -33'sd16384, 16'd1, 8'd1, 8'd1)};
    tbl[2] = '{mode: 2, st: mk(17'd65025, 32'd1065369600, -33'sd1065369600, 16'd65025, 8'd255, 8'd255)};
    tbl[3] = '{mode: 3, st: mk(17'd1, 32'd1, 33'd1, 16'd1, 8'd17, 8'd3)};
    gen_full = model(4, 65536);
    gen_part = model(4, 1998);

    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      rst_v[i]   = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
    for (int i = 0; i < NI; i++) check_reset(i);

    @(negedge clk);
    n0 = ecount;
    for (int i = 0; i < NI; i++) start_v[i] = 1'b1;
    for (int i = 0; i < 4; i++) sb_q.push_back('{inst: i, cyc: n0 + 65538, st: tbl[i].st});
    sb_q.push_back('{inst: 4, cyc: n0 + 65538, st: gen_full});

    for (int k = 0; k <= 68541; k++) begin
      if (k == 1) begin
        for (int i = 0; i < NI; i++) if (i != 4) start_v[i] = 1'b0;
      end
      if (k >= 1 && k <= 65536) begin
        chk("op_ab", 0, 64'({opa_o[0], opb_o[0]}), 64'(k - 1));
        chk("busy_run", 0, 64'(busy_o[0]), 64'd1);
      end
      if (k == 65537) chk("busy_drain", 0, 64'(busy_o[0]), 64'd1);
      if (k == 65538) chk("busy_at_done", 0, 64'(busy_o[0]), 64'd0);
      if (k == 65545) begin
        chk("op_hold", 0, 64'({opa_o[0], opb_o[0]}), 64'hFFFF);
        chk("busy_idle", 0, 64'(busy_o[0]), 64'd0);
      end
      // Mid-sweep partial statistics, then abort and restart on engine 5.
      if (k == 2000) check_stats("partial", 5, gen_part);
      if (k == 3000) rst_v[5] = 1'b1;
      if (k == 3001) begin
        check_reset(5);
        rst_v[5] = 1'b0;
        start_v[5] = 1'b1;
        sb_q.push_back('{inst: 5, cyc: n0 + 3001 + 65538, st: gen_full});
      end
      if (k == 3002) start_v[5] = 1'b0;
      // Engine 4 holds start high: ignored in DONE, restarts from IDLE.
      if (k == 65539) begin
        chk("hold_busy_idle", 4, 64'(busy_o[4]), 64'd0);
        chk("hold_done_idle", 4, 64'(done_o[4]), 64'd0);
        chk("hold_op_idle", 4, 64'({opa_o[4], opb_o[4]}), 64'hFFFF);
      end
      if (k == 65540) begin
        chk("restart_busy", 4, 64'(busy_o[4]), 64'd1);
        chk("restart_op", 4, 64'({opa_o[4], opb_o[4]}), 64'h0000);
        check_stats("restart", 4, '0);
        start_v[4] = 1'b0;
      end
      @(negedge clk);
    end

    // Final statistics hold in IDLE after the sweep.
    for (int i = 0; i < 4; i++) check_stats("final", i, tbl[i].st);
    check_stats("final", 5, gen_full);

    foreach (sb_q[j]) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_done inst%0d: got no pulse expected done at cycle %0d", sb_q[j].inst, sb_q[j].cyc - n0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
